hv_assoc_search: RTL
====================

Name: hv_assoc_search

Overview:
Associative-memory reader for the HDC seizure classifier. Class prototype hypervectors, produced by the bundler during training, are written into this block's prototype store. At inference a query hypervector is compared against every prototype by Hamming distance. The block returns the index and distance of the nearest class. Distance is evaluated CHUNK_W bits per cycle to bound popcount area.

Parameters:
DIMENSIONS, 10000, hypervector width in bits
NUM_CLASSES, 2, number of stored prototypes (seizure / non-seizure); must be >= 2
CHUNK_W, 100, bits compared per cycle; DIMENSIONS % CHUNK_W must be 0 (elaboration error otherwise)

Ports:
clk  input  1  clock, all logic on rising edge
nrst  input  1  reset; one clock; reset is synchronous and active-high (nrst=1 resets on the next rising clk edge)
proto_we  input  1  prototype write strobe
proto_idx  input  $clog2(NUM_CLASSES)  prototype slot to write
proto_hv  input  DIMENSIONS  prototype data
query_valid  input  1  query offered
query_ready  output  1  block can accept a query
query_hv  input  DIMENSIONS  query hypervector
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
class_out  output  $clog2(NUM_CLASSES)  index of nearest prototype
dist_out  output  $clog2(DIMENSIONS+1)  Hamming distance to that prototype

Behaviour:
- Reset: state=IDLE, query_ready=1, result_valid=0, class_out=0, dist_out=0, counters=0. Prototype store is cleared to all-zeros.
- Reset mid-operation aborts any compute or pending result. No result is emitted for the aborted query.
- Prototype write: accepted only in IDLE when proto_we=1. proto_hv is stored to slot proto_idx on that edge. A write with proto_idx >= NUM_CLASSES is ignored. Writes in any other state are ignored and do not stall.
- In IDLE with proto_we=1 and query_valid=1 on the same edge: the write takes effect and the query is also accepted. The query uses the newly written prototype.
- FSM IDLE -> COMPUTE -> FINAL -> DONE -> IDLE:
  - IDLE: query_ready=1. On query_valid=1, latch query_hv, set chunk=0, class=0, acc=0, best_dist=all-ones, best_class=0, then go to COMPUTE.
  - COMPUTE: each cycle, acc += popcount(query[chunk] ^ proto[class][chunk]).
    - On the last chunk of a class: compare that class's total against best and, if strictly less, update best_dist and best_class. Then clear acc, set chunk=0, class++.
    - After the last chunk of the last class, go to FINAL. query_ready=0.
  - FINAL: one cycle. Registers class_out and dist_out from best, then goes to DONE.
  - DONE: result_valid=1. Outputs are held stable until result_ready=1, then return to IDLE. query_ready stays 0 in DONE, so a new query is never accepted on the same edge as the result handshake.
- Tie-break: strict-less compare, so the lowest index wins on equal distance.
- Latency: the accepting edge is cycle 0. result_valid is high from cycle NUM_CLASSES*(DIMENSIONS/CHUNK_W)+2 onward.
- Throughput: one query per NUM_CLASSES*DIMENSIONS/CHUNK_W+3 cycles, assuming result_ready=1.
- Arithmetic: acc and best_dist are $clog2(DIMENSIONS+1) bits wide and cannot overflow. Maximum distance is DIMENSIONS. Identical vectors give dist_out=0.
- result_ready outside DONE is ignored.

Decomposition:
- Package hdc_pkg holds:
  - the state enum search_state_t {IDLE, COMPUTE, FINAL, DONE}
  - function clog2-based width constants DIST_W and IDX_W
  - the CHUNK_W divisibility check macro
- Sub-module hv_popcount (parameter WIDTH): combinational popcount of a WIDTH-bit vector, implemented as an adder tree. It is instantiated once with WIDTH=CHUNK_W.
- Prototype storage is a register array inside hv_assoc_search.

Test Plan:
Bench parameters: DIMENSIONS=8, CHUNK_W=4, NUM_CLASSES=3. Expected latency is 8 cycles.
1. Basic search: write protos 00000000, 11110000, 11111111; query 11110001 -> result_valid at cycle 8, class_out=1, dist_out=1.
2. Tie-break: same protos, query 00001111 (distances 4, 8, 4) -> class_out=0, dist_out=4. Exact match: query 11111111 -> class_out=2, dist_out=0.
3. Backpressure: hold result_ready=0 for 5 cycles after result_valid -> class_out, dist_out and result_valid stay stable; query_ready=0 throughout; the state returns to IDLE one cycle after result_ready=1.
4. Write during busy: assert proto_we to slot 1 with 00000000 during COMPUTE -> ignored. A following query 11110001 still returns class_out=1, dist_out=1. A write with proto_idx=3 in IDLE is ignored.
5. Reset mid-compute: assert nrst=1 at cycle 3 of COMPUTE -> next edge gives query_ready=1, result_valid=0, outputs 0, prototypes all-zero. A subsequent query 00000001 returns class_out=0, dist_out=1.
6. Back-to-back: queries 11110001 then 00000011 with query_valid held high and result_ready=1 -> results (1,1) then (0,2), each query accepted the cycle after the prior result handshake.

Source files
------------

// File: rtl/hv_assoc_search_pkg.sv
// Shared types, width helpers and the elaboration check for the HDC associative search.

`ifndef HV_ASSOC_SEARCH_PKG_SV
`define HV_ASSOC_SEARCH_PKG_SV

// Elaboration-time guard: the distance datapath walks whole chunks only.
`define HDC_CHECK_CHUNK(DIMS, CHUNK) \
   if (((DIMS) % (CHUNK)) != 0) begin : g_chunk_check \
      $error("hv_assoc_search: DIMENSIONS must be a multiple of CHUNK_W"); \
   end

package hdc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      FINAL,
      DONE
   } search_state_t;

   // Distance width: must hold every value from 0 up to the full dimension count.
   function automatic int dist_w(input int dims);
      return $clog2(dims + 1);
   endfunction

   // Class index width, never narrower than one bit.
   function automatic int idx_w(input int classes);
      return (classes < 2) ? 1 : $clog2(classes);
   endfunction

endpackage

`endif

// File: rtl/hv_assoc_search_popcount.sv
// Combinational population count built as a recursive balanced adder tree.

module hv_popcount #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           vec,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int OUT_W = $clog2(WIDTH + 1);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign count = vec;
      end else begin : g_tree
         localparam int LO_W = WIDTH / 2;
         localparam int HI_W = WIDTH - LO_W;

         logic [$clog2(LO_W+1)-1:0] lo_count;
         logic [$clog2(HI_W+1)-1:0] hi_count;

         hv_popcount #(.WIDTH(LO_W)) u_lo (
            .vec   (vec[LO_W-1:0]),
            .count (lo_count)
         );

         hv_popcount #(.WIDTH(HI_W)) u_hi (
            .vec   (vec[WIDTH-1:LO_W]),
            .count (hi_count)
         );

         assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
      end
   endgenerate

endmodule

// File: rtl/hv_assoc_search.sv
// Associative memory: nearest-prototype search by chunked Hamming distance.

module hv_assoc_search
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS  = 10000,
   parameter int NUM_CLASSES = 2,
   parameter int CHUNK_W     = 100
) (
   input  logic                             clk,
   input  logic                             nrst,
   input  logic                             proto_we,
   input  logic [idx_w(NUM_CLASSES)-1:0]    proto_idx,
   input  logic [DIMENSIONS-1:0]            proto_hv,
   input  logic                             query_valid,
   output logic                             query_ready,
   input  logic [DIMENSIONS-1:0]            query_hv,
   output logic                             result_valid,
   input  logic                             result_ready,
   output logic [idx_w(NUM_CLASSES)-1:0]    class_out,
   output logic [dist_w(DIMENSIONS)-1:0]    dist_out
);

   localparam int IDX_W       = idx_w(NUM_CLASSES);
   localparam int DIST_W      = dist_w(DIMENSIONS);
   localparam int NUM_CHUNKS  = DIMENSIONS / CHUNK_W;
   localparam int CHUNK_CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int POP_W       = $clog2(CHUNK_W + 1);

   localparam logic [CHUNK_CNT_W-1:0] LAST_CHUNK = CHUNK_CNT_W'(NUM_CHUNKS - 1);
   localparam logic [IDX_W-1:0]       LAST_CLASS = IDX_W'(NUM_CLASSES - 1);

   `HDC_CHECK_CHUNK(DIMENSIONS, CHUNK_W)

   search_state_t           state;
   logic [DIMENSIONS-1:0]   proto_mem [NUM_CLASSES];
   logic [DIMENSIONS-1:0]   query_q;
   logic [CHUNK_CNT_W-1:0]  chunk_cnt;
   logic [IDX_W-1:0]        class_cnt;
   logic [DIST_W-1:0]       acc;
   logic [DIST_W-1:0]       best_dist;
   logic [IDX_W-1:0]        best_class;

   logic [CHUNK_W-1:0]      q_chunk;
   logic [CHUNK_W-1:0]      p_chunk;
   logic [CHUNK_W-1:0]      diff_chunk;
   logic [POP_W-1:0]        chunk_pop;
   logic [DIST_W-1:0]       class_total;

   // Select the current chunk of the query and of the prototype under test.
   always_comb begin
      q_chunk     = query_q[int'(chunk_cnt)*CHUNK_W +: CHUNK_W];
      p_chunk     = proto_mem[class_cnt][int'(chunk_cnt)*CHUNK_W +: CHUNK_W];
      diff_chunk  = q_chunk ^ p_chunk;
      class_total = acc + DIST_W'(chunk_pop);
   end

   hv_popcount #(.WIDTH(CHUNK_W)) u_popcount (
      .vec   (diff_chunk),
      .count (chunk_pop)
   );

   // Search FSM: accept query, sweep classes chunk by chunk, publish best, await handshake.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state        <= IDLE;
         query_ready  <= 1'b1;
         result_valid <= 1'b0;
         class_out    <= '0;
         dist_out     <= '0;
         query_q      <= '0;
         chunk_cnt    <= '0;
         class_cnt    <= '0;
         acc          <= '0;
         best_dist    <= '0;
         best_class   <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            proto_mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (proto_we && (int'(proto_idx) < NUM_CLASSES)) begin
                  proto_mem[proto_idx] <= proto_hv;
               end
               if (query_valid) begin
                  query_q     <= query_hv;
                  chunk_cnt   <= '0;
                  class_cnt   <= '0;
                  acc         <= '0;
                  best_dist   <= '1;
                  best_class  <= '0;
                  query_ready <= 1'b0;
                  state       <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (chunk_cnt == LAST_CHUNK) begin
                  if (class_total < best_dist) begin
                     best_dist  <= class_total;
                     best_class <= class_cnt;
                  end
                  acc       <= '0;
                  chunk_cnt <= '0;
                  if (class_cnt == LAST_CLASS) begin
                     state <= FINAL;
                  end else begin
                     class_cnt <= class_cnt + IDX_W'(1);
                  end
               end else begin
                  acc       <= class_total;
                  chunk_cnt <= chunk_cnt + CHUNK_CNT_W'(1);
               end
            end
            FINAL: begin
               class_out    <= best_class;
               dist_out     <= best_dist;
               result_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  query_ready  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
